dcr_issue_stage: RTL

Decode-to-execute issue stage of the single-core pipeline. It sits directly upstream of the 32x32 register file read ports and captures operands into the ID/EX pipeline register. A 32-entry scoreboard tracks registers with an outstanding write, and the stage stalls issue on RAW and WAW hazards. Operands are read combinationally from the register file, whose write-to-read bypass covers same-cycle writebacks.

---
 rtl/dcr_pkg.sv | 28 ++
 rtl/dcr_issue_stage_if.sv | 47 ++++
 rtl/dcr_scoreboard.sv | 48 ++++
 rtl/dcr_issue_stage.sv | 94 +++++++++
 4 files changed

// File: rtl/dcr_pkg.sv
// Shared constants and types for the decode-to-execute issue stage.
package dcr_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    typedef logic [XLEN-1:0]     word_t;
    typedef logic [REG_AW-1:0]   reg_idx_t;
    typedef logic [NUM_REGS-1:0] reg_mask_t;

    // Width-independent part of an ID/EX entry; the stage appends its CTL_W-wide control word.
    typedef struct packed {
        word_t    op1;
        word_t    op2;
        reg_idx_t rd;
        logic     rd_we;
    } issue_hdr_t;

    // One-hot register mask; register 0 is never tracked.
    function automatic reg_mask_t reg_onehot(input logic en, input reg_idx_t idx);
        reg_mask_t m;
        m = '0;
        if (en && idx != '0) m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/dcr_issue_stage_if.sv
// Decode-side, register-file, writeback and ID/EX signals of the issue stage.
interface dcr_issue_stage_if
    import dcr_pkg::*;
#(
    parameter int CTL_W = 16
);

    logic             in_valid;
    logic             in_ready;
    reg_idx_t         in_rs1;
    reg_idx_t         in_rs2;
    reg_idx_t         in_rd;
    logic             in_rd_we;
    logic [CTL_W-1:0] in_ctl;

    reg_idx_t         rf_rdaddr1;
    reg_idx_t         rf_rdaddr2;
    word_t            rf_rddata1;
    word_t            rf_rddata2;

    logic             wb_wren;
    reg_idx_t         wb_wraddr;
    logic             flush;

    logic             out_valid;
    logic             out_ready;
    word_t            out_op1;
    word_t            out_op2;
    reg_idx_t         out_rd;
    logic             out_rd_we;
    logic [CTL_W-1:0] out_ctl;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_ctl,
        output rf_rddata1, rf_rddata2, wb_wren, wb_wraddr, flush, out_ready,
        input  in_ready, rf_rdaddr1, rf_rdaddr2,
        input  out_valid, out_op1, out_op2, out_rd, out_rd_we, out_ctl
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_ctl,
        input  rf_rddata1, rf_rddata2, wb_wren, wb_wraddr, flush, out_ready,
        output in_ready, rf_rdaddr1, rf_rdaddr2,
        output out_valid, out_op1, out_op2, out_rd, out_rd_we, out_ctl
    );

endinterface

// File: rtl/dcr_scoreboard.sv
// Pending-write scoreboard: one bit per register with a writer in flight.
module dcr_scoreboard
    import dcr_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     wb_wren,
    input  reg_idx_t wb_wraddr,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     flush_clr_en,
    input  reg_idx_t flush_idx,
    input  reg_idx_t rs1_idx,
    input  reg_idx_t rs2_idx,
    input  reg_idx_t rd_idx,
    output logic     rs1_busy,
    output logic     rs2_busy,
    output logic     rd_busy
);

    reg_mask_t pending;
    reg_mask_t wb_clr;
    reg_mask_t flush_clr;
    reg_mask_t set_mask;
    reg_mask_t busy;

    assign wb_clr    = reg_onehot(wb_wren, wb_wraddr);
    assign flush_clr = reg_onehot(flush_clr_en, flush_idx);
    assign set_mask  = reg_onehot(set_en, set_idx);

    // A same-cycle writeback releases its register, so the dependent can issue on the bypass.
    assign busy = pending & ~wb_clr;

    assign rs1_busy = busy[rs1_idx];
    assign rs2_busy = busy[rs2_idx];
    assign rd_busy  = busy[rd_idx];

    // NOTE: async reset goes in the sensitivity list; state updates use <= so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~wb_clr & ~flush_clr) | set_mask;
        end
    end

endmodule

// File: rtl/dcr_issue_stage.sv
// Issue stage: hazard-gated handshake into the ID/EX register plus a saturating stall counter.
module dcr_issue_stage
    import dcr_pkg::*;
#(
    parameter int CTL_W = 16,
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             rst,
    dcr_issue_stage_if.slave bus,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        issue_hdr_t       hdr;
        logic [CTL_W-1:0] ctl;
    } issue_pkt_t;

    issue_pkt_t in_pkt;
    issue_pkt_t out_q;
    logic       out_valid_q;
    logic       rs1_busy;
    logic       rs2_busy;
    logic       rd_busy;
    logic       hazard;
    logic       in_ready;
    logic       issue;

    assign bus.rf_rdaddr1 = bus.in_rs1;
    assign bus.rf_rdaddr2 = bus.in_rs2;

    dcr_scoreboard u_sb (
        .clk          (clk),
        .rst          (rst),
        .wb_wren      (bus.wb_wren),
        .wb_wraddr    (bus.wb_wraddr),
        .set_en       (issue & bus.in_rd_we),
        .set_idx      (bus.in_rd),
        .flush_clr_en (bus.flush & out_valid_q & out_q.hdr.rd_we),
        .flush_idx    (out_q.hdr.rd),
        .rs1_idx      (bus.in_rs1),
        .rs2_idx      (bus.in_rs2),
        .rd_idx       (bus.in_rd),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rd_busy      (rd_busy)
    );

    assign hazard   = rs1_busy | rs2_busy | (bus.in_rd_we & rd_busy);
    assign in_ready = ~hazard & ~bus.flush & (~out_valid_q | bus.out_ready);
    assign issue    = bus.in_valid & in_ready;

    assign in_pkt.hdr.op1   = bus.rf_rddata1;
    assign in_pkt.hdr.op2   = bus.rf_rddata2;
    assign in_pkt.hdr.rd    = bus.in_rd;
    assign in_pkt.hdr.rd_we = bus.in_rd_we;
    assign in_pkt.ctl       = bus.in_ctl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else if (issue) begin
            out_valid_q <= 1'b1;
        end else if (bus.flush || bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Payload only moves on issue; a flush kills the valid bit but leaves the data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else if (issue) begin
            out_q <= in_pkt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (bus.in_valid && !in_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_op1   = out_q.hdr.op1;
    assign bus.out_op2   = out_q.hdr.op2;
    assign bus.out_rd    = out_q.hdr.rd;
    assign bus.out_rd_we = out_q.hdr.rd_we;
    assign bus.out_ctl   = out_q.ctl;

endmodule
